// File: rtl/mist_track_pkg.sv
// Shared types and constants for the MiST floppy track cache.
// Consumed by mist_track_buf and mist_track_cache.
package mist_track_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT_HI,
        ST_WAIT_LO
    } seq_state_t;

    localparam int SECTOR_BYTES = 512;

    // Sliced to TRACK_W bits by the user; all-ones means "no track loaded".
    localparam logic [15:0] TRACK_INVALID = 16'hFFFF;

endpackage

// File: rtl/mist_track_buf.sv
// One true-dual-port byte RAM holding a whole track image for one drive.
// Port A faces the IO controller, port B the disk controller; A wins on collisions.
module mist_track_buf
    import mist_track_pkg::*;
#(
    parameter int DEPTH = 13 * SECTOR_BYTES,
    parameter int AW    = 13
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic [AW-1:0] a_addr,
    input  logic          a_we,
    input  logic [7:0]    a_di,
    output logic [7:0]    a_do,
    input  logic [AW-1:0] b_addr,
    input  logic          b_we,
    input  logic [7:0]    b_di,
    output logic [7:0]    b_do
);

    logic [7:0] mem [DEPTH];

    // Port A is written last so IO-side data wins on a same-address collision.
    always_ff @(posedge clk) begin
        if (b_we) mem[b_addr] <= b_di;
        if (a_we) mem[a_addr] <= a_di;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            a_do <= 8'h00;
            b_do <= 8'h00;
        end else begin
            a_do <= mem[a_addr];
            b_do <= mem[b_addr];
        end
    end

endmodule

// File: rtl/mist_track_cache.sv
// Per-drive track buffers plus a single sequencer that loads/writes back whole tracks.
// Define MIST_TRACK_WRITEBACK_EN to enable dirty tracking and sector write-back.
module mist_track_cache
    import mist_track_pkg::*;
#(
    parameter int NUM_DRIVES = 2,
    parameter int SECTORS    = 13,
    parameter int TRACK_W    = 6,
    localparam int ADDR_W    = $clog2(SECTORS * SECTOR_BYTES),
    localparam int DRV_W     = (NUM_DRIVES > 1) ? $clog2(NUM_DRIVES) : 1
) (
    input  logic                          clk,
    input  logic                          reset_n,
    output logic [31:0]                   sd_lba,
    output logic [NUM_DRIVES-1:0]         sd_rd,
    output logic [NUM_DRIVES-1:0]         sd_wr,
    input  logic                          sd_ack,
    input  logic [8:0]                    sd_buff_addr,
    input  logic [7:0]                    sd_buff_dout,
    output logic [7:0]                    sd_buff_din,
    input  logic                          sd_buff_wr,
    input  logic [NUM_DRIVES-1:0]         change,
    input  logic [NUM_DRIVES-1:0]         mount,
    input  logic [NUM_DRIVES-1:0]         active,
    input  logic [NUM_DRIVES*TRACK_W-1:0] track,
    output logic [NUM_DRIVES-1:0]         ready,
    output logic [NUM_DRIVES-1:0]         busy,
    input  logic [DRV_W-1:0]              ram_drive,
    input  logic [ADDR_W-1:0]             ram_addr,
    input  logic [7:0]                    ram_di,
    input  logic                          ram_we,
    output logic [7:0]                    ram_do,
    output seq_state_t                    dbg_state
);

`ifdef MIST_TRACK_WRITEBACK_EN
    localparam bit WB_EN = 1'b1;
`else
    localparam bit WB_EN = 1'b0;
`endif

    localparam int REL_W = ADDR_W - 9;
    localparam logic [TRACK_W-1:0] TRK_INV = TRACK_INVALID[TRACK_W-1:0];
    localparam logic [REL_W-1:0] LAST_SEC = REL_W'(SECTORS - 1);

    function automatic logic [31:0] track_lba(input logic [TRACK_W-1:0] t);
        return 32'(t) * 32'(SECTORS);
    endfunction

    seq_state_t           state;
    logic [TRACK_W-1:0]   cur_track [NUM_DRIVES];
    logic [TRACK_W-1:0]   trk       [NUM_DRIVES];
    logic [NUM_DRIVES-1:0] dirty, ready_q, change_q, chg_pend, busy_q, sd_rd_q, sd_wr_q;
    logic [NUM_DRIVES-1:0] need, change_rise, change_fall, loading;
    logic [DRV_W-1:0]     job_drv, rr_ptr, ram_drive_q, pick_drv;
    logic                 job_wb, job_abort, pick_valid, pick_wb, we_dirty, abort_now;
    logic [TRACK_W-1:0]   job_track;
    logic [REL_W-1:0]     rel_sector;
    logic [31:0]          lba;
    logic [7:0]           a_do [NUM_DRIVES];
    logic [7:0]           b_do [NUM_DRIVES];

    assign change_rise = change & ~change_q;
    assign change_fall = ~change & change_q;
    assign loading     = busy_q & ~{NUM_DRIVES{job_wb}};
    assign we_dirty    = WB_EN && ram_we && ready_q[ram_drive] && !loading[ram_drive];
    assign abort_now   = change_rise[job_drv];

    // A drive is held off while its change strobe is high so a swap causes one reload.
    always_comb begin
        need = '0;
        for (int i = 0; i < NUM_DRIVES; i++) begin
            trk[i]  = track[i*TRACK_W +: TRACK_W];
            need[i] = ready_q[i] && !change[i] &&
                      ((cur_track[i] != trk[i]) || chg_pend[i] || (dirty[i] && !active[i]));
        end
    end

    // Round-robin: scan from the drive after rr_ptr; descending loop so the nearest wins.
    always_comb begin
        int idx;
        idx        = 0;
        pick_valid = 1'b0;
        pick_drv   = '0;
        for (int k = NUM_DRIVES; k >= 1; k--) begin
            idx = (int'(rr_ptr) + k) % NUM_DRIVES;
            if (need[idx]) begin
                pick_valid = 1'b1;
                pick_drv   = DRV_W'(idx);
            end
        end
        pick_wb = WB_EN && dirty[pick_drv] && (cur_track[pick_drv] != TRK_INV);
    end

    // Handshake: sd_rd/sd_wr[d] rises after ISSUE and drops on the first cycle sd_ack
    // is seen high; the sector is complete when sd_ack falls again.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= ST_IDLE;
            dirty       <= '0;
            ready_q     <= '0;
            change_q    <= '0;
            chg_pend    <= '0;
            busy_q      <= '0;
            sd_rd_q     <= '0;
            sd_wr_q     <= '0;
            job_drv     <= '0;
            rr_ptr      <= '0;
            ram_drive_q <= '0;
            job_wb      <= 1'b0;
            job_abort   <= 1'b0;
            job_track   <= TRK_INV;
            rel_sector  <= '0;
            lba         <= 32'd0;
            for (int i = 0; i < NUM_DRIVES; i++) cur_track[i] <= TRK_INV;
        end else begin
            change_q    <= change;
            ram_drive_q <= ram_drive;
            chg_pend    <= chg_pend | change_fall;
            if (we_dirty) dirty[ram_drive] <= 1'b1;

            case (state)
                ST_IDLE: begin
                    if (pick_valid) begin
                        job_drv            <= pick_drv;
                        busy_q[pick_drv]   <= 1'b1;
                        chg_pend[pick_drv] <= 1'b0;
                        job_wb             <= pick_wb;
                        job_track          <= trk[pick_drv];
                        lba                <= track_lba(pick_wb ? cur_track[pick_drv] : trk[pick_drv]);
                        rel_sector         <= '0;
                        job_abort          <= 1'b0;
                        state              <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (abort_now) begin
                        busy_q[job_drv] <= 1'b0;
                        rr_ptr          <= job_drv;
                        state           <= ST_IDLE;
                    end else begin
                        if (job_wb) sd_wr_q[job_drv] <= 1'b1;
                        else        sd_rd_q[job_drv] <= 1'b1;
                        state <= ST_WAIT_HI;
                    end
                end
                ST_WAIT_HI: begin
                    if (abort_now || sd_ack) begin
                        sd_rd_q <= '0;
                        sd_wr_q <= '0;
                    end
                    if (abort_now) begin
                        busy_q[job_drv] <= 1'b0;
                        rr_ptr          <= job_drv;
                        state           <= ST_IDLE;
                    end else if (sd_ack) begin
                        state <= ST_WAIT_LO;
                    end
                end
                ST_WAIT_LO: begin
                    if (abort_now) job_abort <= 1'b1;
                    if (!sd_ack) begin
                        if (job_abort || abort_now) begin
                            busy_q[job_drv] <= 1'b0;
                            rr_ptr          <= job_drv;
                            state           <= ST_IDLE;
                        end else if (rel_sector != LAST_SEC) begin
                            lba        <= lba + 32'd1;
                            rel_sector <= rel_sector + 1'b1;
                            state      <= ST_ISSUE;
                        end else if (job_wb && (cur_track[job_drv] != trk[job_drv])) begin
                            job_wb     <= 1'b0;
                            job_track  <= trk[job_drv];
                            lba        <= track_lba(trk[job_drv]);
                            rel_sector <= '0;
                            state      <= ST_ISSUE;
                        end else begin
                            // Latched job_track keeps cur_track honest if track moved mid-load.
                            dirty[job_drv] <= 1'b0;
                            if (!job_wb) cur_track[job_drv] <= job_track;
                            busy_q[job_drv] <= 1'b0;
                            rr_ptr          <= job_drv;
                            state           <= ST_IDLE;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase

            for (int i = 0; i < NUM_DRIVES; i++) begin
                if (change_rise[i]) begin
                    ready_q[i]   <= mount[i];
                    cur_track[i] <= TRK_INV;
                    dirty[i]     <= 1'b0;
                end
            end
        end
    end

    for (genvar d = 0; d < NUM_DRIVES; d++) begin : g_buf
        mist_track_buf #(
            .DEPTH (SECTORS * SECTOR_BYTES),
            .AW    (ADDR_W)
        ) u_buf (
            .clk     (clk),
            .reset_n (reset_n),
            .a_addr  ({rel_sector, sd_buff_addr}),
            .a_we    (sd_buff_wr && sd_ack && (state != ST_IDLE) && (job_drv == DRV_W'(d))),
            .a_di    (sd_buff_dout),
            .a_do    (a_do[d]),
            .b_addr  (ram_addr),
            .b_we    (ram_we && (ram_drive == DRV_W'(d))),
            .b_di    (ram_di),
            .b_do    (b_do[d])
        );
    end

    assign sd_buff_din = a_do[job_drv];
    assign ram_do      = b_do[ram_drive_q];
    assign sd_lba      = lba;
    assign sd_rd       = sd_rd_q;
    assign sd_wr       = sd_wr_q & {NUM_DRIVES{WB_EN}};
    assign ready       = ready_q;
    assign busy        = busy_q;
    assign dbg_state   = state;

endmodule

// File: tb/tb_mist_track_cache.sv
// Directed bench for mist_track_cache with a small IO-controller model.
// Write-back scenarios run only when MIST_TRACK_WRITEBACK_EN is defined.
module tb_mist_track_cache;
    import mist_track_pkg::*;

    localparam int ND = 2;

    logic        clk;
    logic        reset_n;
    logic [31:0] sd_lba;
    logic [1:0]  sd_rd, sd_wr;
    logic        sd_ack;
    logic [8:0]  sd_buff_addr;
    logic [7:0]  sd_buff_dout, sd_buff_din;
    logic        sd_buff_wr;
    logic [1:0]  change, mount, active;
    logic [11:0] track;
    logic [1:0]  ready, busy;
    logic [0:0]  ram_drive;
    logic [12:0] ram_addr;
    logic [7:0]  ram_di, ram_do;
    logic        ram_we;
    seq_state_t  dbg_state;

    int n_vec = 0;
    int n_err = 0;

    mist_track_cache dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .sd_lba       (sd_lba),
        .sd_rd        (sd_rd),
        .sd_wr        (sd_wr),
        .sd_ack       (sd_ack),
        .sd_buff_addr (sd_buff_addr),
        .sd_buff_dout (sd_buff_dout),
        .sd_buff_din  (sd_buff_din),
        .sd_buff_wr   (sd_buff_wr),
        .change       (change),
        .mount        (mount),
        .active       (active),
        .track        (track),
        .ready        (ready),
        .busy         (busy),
        .ram_drive    (ram_drive),
        .ram_addr     (ram_addr),
        .ram_di       (ram_di),
        .ram_we       (ram_we),
        .ram_do       (ram_do),
        .dbg_state    (dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // driver tasks
    task automatic wait_req(input int budget, output bit ok, output bit saw_idle);
        ok       = 1'b0;
        saw_idle = 1'b0;
        for (int n = 0; n < budget; n++) begin
            @(negedge clk);
            if (|(sd_rd | sd_wr)) begin
                ok = 1'b1;
                break;
            end
            if (dbg_state == ST_IDLE) saw_idle = 1'b1;
        end
    endtask

    task automatic serve_sector(input int exp_drv, input bit exp_wr, input logic [31:0] exp_lba,
                                input bit chk_din, input logic [7:0] exp_din, input bit pulse0,
                                output bit saw_idle);
        bit ok;
        int drv;
        string t;
        t = $sformatf("lba%0d", exp_lba);
        wait_req(200, ok, saw_idle);
        check_val({t, "_req_seen"}, 32'(ok), 32'd1);
        if (!ok) return;
        drv = (sd_rd[1] | sd_wr[1]) ? 1 : 0;
        check_val({t, "_drv"}, 32'(drv), 32'(exp_drv));
        check_val({t, "_type_wr"}, 32'(|sd_wr), 32'(exp_wr));
        check_val({t, "_lba"}, sd_lba, exp_lba);
        check_val({t, "_busy"}, 32'(busy), 32'(1 << exp_drv));
        sd_ack = 1'b1;
        @(negedge clk);
        check_val({t, "_req_clr"}, 32'({sd_rd, sd_wr}), 32'd0);
        if (pulse0) begin
            change[0] = 1'b1;
            mount[0]  = 1'b0;
        end
        if (!exp_wr) begin
            sd_buff_addr = 9'h000;
            sd_buff_dout = exp_lba[7:0];
            sd_buff_wr   = 1'b1;
            @(negedge clk);
            change[0]    = 1'b0;
            sd_buff_addr = 9'h1FF;
            sd_buff_dout = ~exp_lba[7:0];
            @(negedge clk);
            sd_buff_wr   = 1'b0;
        end else begin
            sd_buff_addr = 9'h100;
            @(negedge clk);
            change[0] = 1'b0;
            if (chk_din) check_val({t, "_buff_din"}, 32'(sd_buff_din), 32'(exp_din));
        end
        sd_ack = 1'b0;
    endtask

    task automatic serve_track(input int drv, input bit wr, input logic [31:0] first_lba,
                               input bit chk_din, input logic [7:0] din0, output bit idle_before);
        bit si;
        idle_before = 1'b0;
        for (int i = 0; i < 13; i++) begin
            serve_sector(drv, wr, first_lba + 32'(i), chk_din && (i == 0), din0, 1'b0, si);
            if (i == 0) idle_before = si;
        end
    endtask

    task automatic pulse_change(input logic [1:0] mask, input logic [1:0] mnt);
        @(negedge clk);
        mount  = mnt;
        change = mask;
        @(negedge clk);
        change = 2'b00;
    endtask

    task automatic ram_write(input logic [0:0] drv, input logic [12:0] addr, input logic [7:0] data);
        @(negedge clk);
        ram_drive = drv;
        ram_addr  = addr;
        ram_di    = data;
        ram_we    = 1'b1;
        @(negedge clk);
        ram_we    = 1'b0;
    endtask

    task automatic ram_read(input logic [0:0] drv, input logic [12:0] addr, output logic [7:0] data);
        @(negedge clk);
        ram_drive = drv;
        ram_addr  = addr;
        @(negedge clk);
        data = ram_do;
    endtask

    task automatic expect_quiet(input string tag, input int budget);
        bit ok, si;
        wait_req(budget, ok, si);
        check_val({tag, "_no_req"}, 32'(ok), 32'd0);
    endtask

    initial begin
        logic [7:0] rd;
        bit ok, si, idle_gap;
        reset_n = 1'b0;
        sd_ack = 1'b0; sd_buff_addr = '0; sd_buff_dout = '0; sd_buff_wr = 1'b0;
        change = '0; mount = '0; active = 2'b11;
        track = {6'd0, 6'd3};
        ram_drive = '0; ram_addr = '0; ram_di = '0; ram_we = 1'b0;
        repeat (3) @(negedge clk);
        check_val("rst_sd_rd", 32'(sd_rd), 32'd0);
        check_val("rst_sd_wr", 32'(sd_wr), 32'd0);
        check_val("rst_busy", 32'(busy), 32'd0);
        check_val("rst_ready", 32'(ready), 32'd0);
        check_val("rst_ram_do", 32'(ram_do), 32'd0);
        check_val("rst_buff_din", 32'(sd_buff_din), 32'd0);
        check_val("rst_lba", sd_lba, 32'd0);
        check_val("rst_state", 32'(dbg_state), 32'(ST_IDLE));
        reset_n = 1'b1;

        // mount drive 0 on track 3: reads lba 39..51
        pulse_change(2'b01, 2'b01);
        serve_track(0, 1'b0, 32'd39, 1'b0, 8'h00, idle_gap);
        expect_quiet("load_t3", 20);
        check_val("load_t3_busy", 32'(busy), 32'd0);
        check_val("load_t3_ready", 32'(ready), 32'b01);
        ram_read(1'b0, 13'd2560, rd);
        check_val("ram_do_s5_a0", 32'(rd), 32'h2C);
        ram_read(1'b0, 13'd3071, rd);
        check_val("ram_do_s5_a1ff", 32'(rd), 32'hD3);

`ifndef MIST_TRACK_WRITEBACK_EN
        ram_write(1'b0, 13'h010, 8'h5A);
        ram_read(1'b0, 13'h010, rd);
        check_val("ram_rw", 32'(rd), 32'h5A);
        active = 2'b00;
        expect_quiet("nowb_inactive", 30);
        check_val("nowb_sd_wr", 32'(sd_wr), 32'd0);
        active = 2'b11;
`else
        // write-back then load with no idle gap
        track[5:0] = 6'd2;
        serve_track(0, 1'b0, 32'd26, 1'b0, 8'h00, idle_gap);
        ram_write(1'b0, 13'h020, 8'h77);
        track[5:0] = 6'd7;
        serve_track(0, 1'b1, 32'd26, 1'b0, 8'h00, idle_gap);
        serve_track(0, 1'b0, 32'd91, 1'b0, 8'h00, idle_gap);
        check_val("wb_then_load_no_idle", 32'(idle_gap), 32'd0);
        // motor-off flush of drive 1 on track 5
        track[11:6] = 6'd5;
        pulse_change(2'b10, 2'b11);
        serve_track(1, 1'b0, 32'd65, 1'b0, 8'h00, idle_gap);
        ram_write(1'b1, 13'h100, 8'hA5);
        active[1] = 1'b0;
        serve_track(1, 1'b1, 32'd65, 1'b1, 8'hA5, idle_gap);
        expect_quiet("flush_done", 20);
        track[5:0] = 6'd8;
        serve_track(0, 1'b0, 32'd104, 1'b0, 8'h00, idle_gap);
`endif

        // simultaneous requests after drive 0 served: drive 1 first
        @(negedge clk);
        track  = {6'd4, 6'd6};
        mount  = 2'b11;
        change = 2'b11;
        @(negedge clk);
        change = 2'b00;
        serve_track(1, 1'b0, 32'd52, 1'b0, 8'h00, idle_gap);
        serve_track(0, 1'b0, 32'd78, 1'b0, 8'h00, idle_gap);
        expect_quiet("rr_done", 20);

        // image change on drive 0 during sector 5 of a load of track 2
        track[5:0] = 6'd2;
        for (int i = 0; i < 6; i++) serve_sector(0, 1'b0, 32'd26 + 32'(i), 1'b0, 8'h00, i == 5, si);
        expect_quiet("abort", 30);
        check_val("abort_ready", 32'(ready), 32'b10);
        check_val("abort_busy", 32'(busy), 32'd0);

        // reset in the middle of a job on drive 1
        track[11:6] = 6'd1;
        wait_req(200, ok, si);
        check_val("mid_req_seen", 32'(ok), 32'd1);
        check_val("mid_lba", sd_lba, 32'd13);
        reset_n = 1'b0;
        @(negedge clk);
        check_val("mid_rst_req", 32'({sd_rd, sd_wr}), 32'd0);
        check_val("mid_rst_busy", 32'(busy), 32'd0);
        check_val("mid_rst_ready", 32'(ready), 32'd0);
        check_val("mid_rst_lba", sd_lba, 32'd0);
        check_val("mid_rst_state", 32'(dbg_state), 32'(ST_IDLE));
        reset_n = 1'b1;
        expect_quiet("post_rst", 20);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/mist_track_cache.md
MIST_TRACK_CACHE -- requirements
Module: mist_track_cache

Interface
REQ-001 Parameter NUM_DRIVES, default 2, number of independent drive images/track buffers (1..4).
REQ-002 Parameter SECTORS, default 13, 512-byte sectors per track; ADDR_W = clog2(SECTORS*512) (13 at default).
REQ-003 Parameter TRACK_W, default 6, track-number width; all-ones encodes "no track loaded".
REQ-004 clk  in  1  single clock; all logic on its rising edge.
REQ-005 reset_n  in  1  asynchronous, active-low reset.
REQ-006 sd_lba  out  32  sector address within the image of the serviced drive.
REQ-007 sd_rd / sd_wr  out  NUM_DRIVES each  per-drive sector read/write request.
REQ-008 sd_ack  in  1  IO-controller acknowledge; high while a sector transfers.
REQ-009 sd_buff_addr  in  9; sd_buff_dout  in  8; sd_buff_din  out  8; sd_buff_wr  in  1  sector byte port.
REQ-010 change, mount, active  in  NUM_DRIVES each  image-change strobe, image-present, drive-motor-on.
REQ-011 track  in  NUM_DRIVES*TRACK_W  requested track per drive, drive 0 in LSBs.
REQ-012 ready, busy  out  NUM_DRIVES each  image mounted; drive buffer transfer in progress.
REQ-013 ram_drive  in  clog2(NUM_DRIVES); ram_addr  in  ADDR_W; ram_di  in  8; ram_we  in  1; ram_do  out  8  disk-controller buffer port.

Function
REQ-014 Each drive SHALL own a SECTORS*512-byte dual-port buffer; ram_do is registered, 1-cycle read latency, from buffer ram_drive.
REQ-015 Per drive, cur_track, dirty and ready state SHALL be held; dirty sets on ram_we when ready and that drive not loading.
REQ-016 A drive needs service when ready and (cur_track != track, or falling edge of change, or dirty and ~active).
REQ-017 Sequencer states: IDLE, ISSUE, WAIT_HI, WAIT_LO; one job in flight across all drives.
REQ-018 IDLE picks the requesting drive by round-robin starting after the last serviced drive; pointer advances on job completion.
REQ-019 Job type: write-back if dirty and cur_track valid, else load; lba = zero-extended track*SECTORS (32-bit), rel_sector = 0.
REQ-020 ISSUE asserts sd_rd[d] or sd_wr[d]; request SHALL be cleared on the first cycle sd_ack is high.
REQ-021 On sd_ack falling edge: if rel_sector != SECTORS-1, increment lba and rel_sector and re-issue; else if write-back and cur_track != track, become load of new track; else clear dirty (load: also cur_track <= track), go IDLE.
REQ-022 sd_buff_din SHALL be registered from buffer d at {rel_sector, sd_buff_addr}; sd_buff_wr with sd_ack writes there.
REQ-023 Rising edge of change[d]: ready[d] <= mount[d], cur_track invalid, dirty cleared; if d in flight, no further sectors issued, job ends at next sd_ack falling edge (or immediately if not yet acked).
REQ-024 busy[d] SHALL be high from ISSUE through job end for drive d only.
REQ-025 Same-address same-cycle writes from both ports: IO-side data wins.

Reset
REQ-026 reset_n low: sd_rd, sd_wr, busy, ready, ram_do, sd_buff_din, all dirty = 0; cur_track all-ones; sd_lba 0; state IDLE; RR pointer 0; buffer contents not cleared.

Configuration
REQ-027 Macro MIST_TRACK_WRITEBACK_EN: defined, write-back per REQ-015..021; undefined, dirty never sets, sd_wr tied 0, ram_we still updates buffer (volatile edits lost on track change).

Structure
REQ-028 Package mist_track_pkg SHALL hold the sequencer state enum, SECTOR_BYTES=512 and the invalid-track constant.
REQ-029 Sub-module mist_track_buf: one true-dual-port byte RAM, instantiated NUM_DRIVES times.

Verification
REQ-030 Mount drive 0, track 3 -> sd_rd[0] pulses 13 times, sd_lba 39..51, ready[0]=1, busy[0] low after 13th ack falls.
REQ-031 Write ram_addr 0x100=0xA5 on drive 1 track 5, set active[1]=0 -> 13 sd_wr[1] at lba 65..77; sd_buff_din=0xA5 at sector 0 addr 0x100.
REQ-032 Dirty drive 0 on track 2, request track 7 -> writes lba 26..38, then reads lba 91..103, no IDLE between.
REQ-033 Both drives request simultaneously after serving drive 0 -> drive 1 served first.
REQ-034 change[0] rises during sector 5 of a load -> no sector 6 request; ready[0]=mount[0]; reset_n low mid-job -> all requests 0 next cycle.
